// File: rtl/led_digit_scanner_if.sv
// Bus between the BCD producer / pin drivers and the LED matrix scanner.
//   enable      scan enable
//   load        one-cycle strobe sampling digits_in into the shadow buffer
//   digits_in   4-bit character codes, nibble k is position k (k=0 rightmost)
//   lzb         leading-zero blanking enable
//   brightness  PWM on-time level
//   row_sel     one-hot active-high row drive, bit 0 = top row
//   col_data    column pattern of the current row, 6 bits per character
//   frame_done  one-cycle pulse on the last tick of row 6
interface led_digit_scanner_if #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned BRIGHT_W   = 4
);
    logic                      enable;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   digits_in;
    logic                      lzb;
    logic [BRIGHT_W-1:0]       brightness;
    logic [6:0]                row_sel;
    logic [6*NUM_DIGITS-1:0]   col_data;
    logic                      frame_done;

    modport master (
        output enable, load, digits_in, lzb, brightness,
        input  row_sel, col_data, frame_done
    );

    modport slave (
        input  enable, load, digits_in, lzb, brightness,
        output row_sel, col_data, frame_done
    );
endinterface

// File: rtl/led_digit_scanner.sv
// Row-multiplexed driver for a 5x7 LED matrix showing NUM_DIGITS characters.
// Glyph ROM, double-buffered digit registers, leading-zero blanking, row scan
// with anti-ghost guard ticks and per-row PWM brightness.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         led_digit_scanner_if.slave (inputs: enable, load, digits_in,
//               lzb, brightness; registered outputs: row_sel, col_data,
//               frame_done)
module led_digit_scanner #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned ROW_CYCLES = 1000,
    parameter int unsigned GUARD      = 2,
    parameter int unsigned BRIGHT_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    led_digit_scanner_if.slave bus
);
    localparam int unsigned CODE_W    = 4 * NUM_DIGITS;
    localparam int unsigned COL_W     = 6 * NUM_DIGITS;
    localparam int unsigned TICK_W    = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
    localparam int unsigned LAST_TICK = ROW_CYCLES - 1;
    localparam int unsigned ON_SPAN   = ROW_CYCLES - GUARD;

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } state_t;

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [2:0]          row_q, row_d;
    logic [BRIGHT_W-1:0] bright_q, bright_d;
    logic [CODE_W-1:0]   shadow_q, shadow_d;
    logic [CODE_W-1:0]   active_q, active_d;
    logic [6:0]          row_sel_q, row_sel_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic                fd_q, fd_d;
    logic                row_start;
    logic [31:0]         on_c;

    // 5x7 glyph ROM: row 0 is the top row, bit 4 the leftmost column.
    function automatic logic [4:0] glyph(input logic [3:0] code, input logic [2:0] row);
        logic [34:0] g;
        logic [34:0] sh;
        g = '0;
        case (code)
            4'd0:    g = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E};
            4'd1:    g = {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
            4'd2:    g = {5'h0E, 5'h11, 5'h01, 5'h06, 5'h08, 5'h10, 5'h1F};
            4'd3:    g = {5'h0E, 5'h11, 5'h01, 5'h06, 5'h01, 5'h11, 5'h0E};
            4'd4:    g = {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02};
            4'd5:    g = {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
            4'd6:    g = {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E};
            4'd7:    g = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08};
            4'd8:    g = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
            4'd9:    g = {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C};
            4'd10:   g = {5'h00, 5'h00, 5'h00, 5'h1F, 5'h00, 5'h00, 5'h00};
            default: g = '0;
        endcase
        sh = g << (32'd5 * 32'(row));
        return sh[34:30];
    endfunction

    // One matrix row for all positions; zeros above the most significant
    // nonzero code are blanked when blank_lz is set, position 0 always shows.
    function automatic logic [COL_W-1:0] render(input logic [CODE_W-1:0] codes,
                                                input logic              blank_lz,
                                                input logic [2:0]        row);
        logic [COL_W-1:0] v;
        logic             lead;
        logic [3:0]       c;
        v    = '0;
        lead = blank_lz;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            c = codes[4*k +: 4];
            if (!(lead && (k != 0) && (c == 4'd0))) begin
                lead           = 1'b0;
                v[6*k+1 +: 5]  = glyph(c, row);
            end
        end
        return v;
    endfunction

    // Next-state: scan sequencer, digit buffering and output pattern.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        row_d     = row_q;
        bright_d  = bright_q;
        row_sel_d = '0;
        col_d     = col_q;
        fd_d      = 1'b0;
        row_start = 1'b0;
        on_c      = '0;

        shadow_d = bus.load ? bus.digits_in : shadow_q;
        active_d = active_q;
        // Frame boundary: a coincident load bypasses the shadow buffer.
        if (fd_q) begin
            active_d = bus.load ? bus.digits_in : shadow_q;
        end

        if (!bus.enable) begin
            state_d = S_IDLE;
            tick_d  = '0;
            row_d   = '0;
            col_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d   = S_SCAN;
                    tick_d    = '0;
                    row_d     = '0;
                    row_start = 1'b1;
                end
                S_SCAN: begin
                    if (tick_q == TICK_W'(LAST_TICK)) begin
                        tick_d    = '0;
                        row_d     = (row_q == 3'd6) ? 3'd0 : row_q + 3'd1;
                        row_start = 1'b1;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase

            // Pattern and brightness are latched once per row slot.
            if (row_start) begin
                bright_d = bus.brightness;
                col_d    = render(active_d, bus.lzb, row_d);
            end

            on_c = (ON_SPAN * (32'(bright_d) + 32'd1)) >> BRIGHT_W;
            if ((32'(tick_d) >= GUARD) && (32'(tick_d) < (GUARD + on_c))) begin
                row_sel_d = 7'd1 << row_d;
            end
            fd_d = (row_d == 3'd6) && (tick_d == TICK_W'(LAST_TICK));
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            tick_q    <= '0;
            row_q     <= '0;
            bright_q  <= '0;
            shadow_q  <= '1;
            active_q  <= '1;
            row_sel_q <= '0;
            col_q     <= '0;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            row_q     <= row_d;
            bright_q  <= bright_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            row_sel_q <= row_sel_d;
            col_q     <= col_d;
            fd_q      <= fd_d;
        end
    end

    assign bus.row_sel    = row_sel_q;
    assign bus.col_data   = col_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_led_digit_scanner.sv
// Self-checking bench for led_digit_scanner (NUM_DIGITS=4, ROW_CYCLES=1000,
// GUARD=2, BRIGHT_W=4). Expected rows are queued per frame and compared as
// each row turns on; frame timing is checked against a free-running counter.
module tb_led_digit_scanner;
    localparam int unsigned ROWC  = 1000;
    localparam int unsigned GRD   = 2;
    localparam int unsigned BW    = 4;
    localparam int unsigned FRAME = 7 * ROWC;

    localparam logic [4:0] FONT [11][7] = '{
        '{5'h0E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E},
        '{5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E},
        '{5'h0E, 5'h11, 5'h01, 5'h06, 5'h08, 5'h10, 5'h1F},
        '{5'h0E, 5'h11, 5'h01, 5'h06, 5'h01, 5'h11, 5'h0E},
        '{5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02},
        '{5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E},
        '{5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E},
        '{5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08},
        '{5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E},
        '{5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C},
        '{5'h00, 5'h00, 5'h00, 5'h1F, 5'h00, 5'h00, 5'h00}
    };

    typedef struct {
        logic [6:0]  row;
        logic [23:0] col;
        int          on;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t exp_q[$];

    led_digit_scanner_if #(.NUM_DIGITS(4), .BRIGHT_W(BW)) bus ();

    led_digit_scanner #(
        .NUM_DIGITS(4),
        .ROW_CYCLES(ROWC),
        .GUARD(GRD),
        .BRIGHT_W(BW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [23:0] exp_col(input logic [15:0] codes, input bit lz, input int r);
        logic [23:0] v;
        logic [3:0]  c;
        int          top;
        v   = '0;
        top = 0;
        for (int k = 0; k < 4; k++) if (codes[4*k +: 4] != 4'd0) top = k;
        for (int k = 0; k < 4; k++) begin
            c = codes[4*k +: 4];
            if (!(lz && k > top) && c <= 4'd10) v[6*k+1 +: 5] = FONT[c][r];
        end
        return v;
    endfunction

    function automatic int exp_on(input int b);
        return ((ROWC - GRD) * (b + 1)) / (1 << BW);
    endfunction

    task automatic push_frame(input logic [15:0] codes, input bit lz, input int b);
        exp_t e;
        for (int r = 0; r < 7; r++) begin
            e.row = 7'(1 << r);
            e.col = exp_col(codes, lz, r);
            e.on  = exp_on(b);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_fd(output int at_cyc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_done && n < FRAME + 1000);
        check("fd_seen", 32'(bus.frame_done), 32'd1);
        at_cyc = cyc;
    endtask

    task automatic do_load(input logic [15:0] d);
        bus.load      = 1'b1;
        bus.digits_in = d;
        @(negedge clk);
        bus.load      = 1'b0;
    endtask

    // Row monitor: pops one expected row per row_sel rising, measures on-time.
    initial begin : monitor
        logic [6:0] prev;
        exp_t       e;
        int         on_cnt;
        bit         busy;
        prev   = '0;
        on_cnt = 0;
        busy   = 1'b0;
        forever begin
            @(negedge clk);
            if (busy) begin
                if (bus.row_sel == e.row) on_cnt++;
                else begin
                    check("on_time", 32'(on_cnt), 32'(e.on));
                    busy = 1'b0;
                end
            end
            if (!busy && prev == '0 && bus.row_sel != '0 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("row_sel", 32'(bus.row_sel), 32'(e.row));
                check("col_data", 32'(bus.col_data), 32'(e.col));
                busy   = 1'b1;
                on_cnt = 1;
            end
            prev = bus.row_sel;
        end
    end

    initial begin : main
        int t_fd;
        int t_prev;
        int n;
        rst_n          = 1'b0;
        bus.enable     = 1'b0;
        bus.load       = 1'b0;
        bus.digits_in  = '0;
        bus.lzb        = 1'b0;
        bus.brightness = 4'd15;
        repeat (3) @(negedge clk);
        check("rst_row_sel", 32'(bus.row_sel), 32'd0);
        check("rst_col_data", 32'(bus.col_data), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);

        // Frame 1: blank display; mid-frame load must not show yet.
        rst_n      = 1'b1;
        bus.enable = 1'b1;
        t_prev     = cyc;
        push_frame(16'hFFFF, 1'b0, 15);
        repeat (3500) @(negedge clk);
        do_load(16'h1234);
        wait_fd(t_fd);
        check("period_f1", 32'(t_fd - t_prev), 32'(FRAME));
        t_prev = t_fd;

        // Frame 2: 1234 at half brightness; 0042 loaded during row 3.
        bus.brightness = 4'd7;
        push_frame(16'h1234, 1'b0, 7);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.row_sel == '0 && n < 10);
        check("guard_ticks", 32'(n), 32'(GRD + 1));
        repeat (3400) @(negedge clk);
        do_load(16'h0042);
        wait_fd(t_fd);
        check("period_f2", 32'(t_fd - t_prev), 32'(FRAME));
        t_prev = t_fd;

        // Frame 3: 0042 with blanking, minimum brightness.
        bus.lzb        = 1'b1;
        bus.brightness = 4'd0;
        push_frame(16'h0042, 1'b1, 0);
        @(negedge clk);
        check("fd_width", 32'(bus.frame_done), 32'd0);
        wait_fd(t_fd);
        check("period_f3", 32'(t_fd - t_prev), 32'(FRAME));
        t_prev = t_fd;

        // Frame 4: 0042 without blanking; load minus sign code.
        bus.lzb        = 1'b0;
        bus.brightness = 4'd15;
        push_frame(16'h0042, 1'b0, 15);
        repeat (3500) @(negedge clk);
        do_load(16'hFFFA);
        wait_fd(t_fd);
        t_prev = t_fd;

        // Frame 5: FFFA; load 5555 during row 3 must wait for the frame end.
        push_frame(16'hFFFA, 1'b0, 15);
        repeat (3200) @(negedge clk);
        do_load(16'h5555);
        wait_fd(t_fd);
        t_prev = t_fd;

        // Frame 6: 5555; shadow reloaded mid-frame, then bypassed on frame_done.
        push_frame(16'h5555, 1'b0, 15);
        repeat (3500) @(negedge clk);
        do_load(16'h1111);
        wait_fd(t_fd);
        t_prev        = t_fd;
        bus.load      = 1'b1;
        bus.digits_in = 16'h9999;
        push_frame(16'h9999, 1'b0, 15);
        @(negedge clk);
        bus.load      = 1'b0;

        // Frame 7: 9999; then drop enable in row 2.
        wait_fd(t_fd);
        check("period_f7", 32'(t_fd - t_prev), 32'(FRAME));
        repeat (2500) @(negedge clk);
        check("row2_sel", 32'(bus.row_sel), 32'h4);
        check("row2_col", 32'(bus.col_data), 32'(exp_col(16'h9999, 1'b0, 2)));
        bus.enable = 1'b0;
        @(negedge clk);
        check("dis_row_sel", 32'(bus.row_sel), 32'd0);
        check("dis_col_data", 32'(bus.col_data), 32'd0);
        check("dis_frame_done", 32'(bus.frame_done), 32'd0);
        repeat (20) @(negedge clk);
        check("dis_hold_sel", 32'(bus.row_sel), 32'd0);

        // Frame 8: restart from row 0 tick 0 with retained digits.
        push_frame(16'h9999, 1'b0, 15);
        bus.enable = 1'b1;
        t_prev     = cyc;
        wait_fd(t_fd);
        check("period_reen", 32'(t_fd - t_prev), 32'(FRAME));

        // Asynchronous reset in the middle of row 1.
        repeat (1500) @(negedge clk);
        check("pre_rst_sel", 32'(bus.row_sel), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_row_sel", 32'(bus.row_sel), 32'd0);
        check("async_col_data", 32'(bus.col_data), 32'd0);
        check("async_frame_done", 32'(bus.frame_done), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        t_prev = cyc;
        push_frame(16'hFFFF, 1'b0, 15);
        wait_fd(t_fd);
        check("period_post_rst", 32'(t_fd - t_prev), 32'(FRAME));
        repeat (5) @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
